// File: rtl/dm_pad_input_filter_if.sv
// Bus bundle between the DM pad input filter and the fabric register block.
// The register block is the master: it supplies the raw pads, clear strobes
// and interrupt mask, and it consumes the filtered status.
interface dm_pad_input_filter_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] PAD_IN;
  logic [WIDTH-1:0] evt_clr;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] level_out;
  logic [WIDTH-1:0] rise_pulse;
  logic [WIDTH-1:0] fall_pulse;
  logic [WIDTH-1:0] evt_flag;
  logic             irq;

  modport master (
    output PAD_IN, evt_clr, irq_mask,
    input  level_out, rise_pulse, fall_pulse, evt_flag, irq
  );

  modport slave (
    input  PAD_IN, evt_clr, irq_mask,
    output level_out, rise_pulse, fall_pulse, evt_flag, irq
  );
endinterface

// File: rtl/dm_pad_input_filter.sv
// DM pad input filter: synchronizes asynchronous status/fault/ready pads,
// glitch-filters each bit with a persistence counter, and produces filtered
// levels, edge pulses, sticky event flags and a masked interrupt.
module dm_pad_input_filter #(
  parameter int               WIDTH         = 4,
  parameter int               SYNC_STAGES   = 2,
  parameter int               FILTER_CYCLES = 16,
  parameter logic [WIDTH-1:0] RESET_LEVEL   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  dm_pad_input_filter_if.slave  bus
);

  // Counter only needs to reach FILTER_CYCLES-1; keep at least one bit so
  // FILTER_CYCLES=1 still elaborates (the compare is then always true).
  localparam int               CNT_W   = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILTER_CYCLES - 1);

  logic [WIDTH-1:0] sync_chain_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_chain_d [SYNC_STAGES];
  logic [WIDTH-1:0] sync_q;

  logic [WIDTH-1:0] level_q,    level_d;
  logic [WIDTH-1:0] rise_q,     rise_d;
  logic [WIDTH-1:0] fall_q,     fall_d;
  logic [WIDTH-1:0] evt_flag_q, evt_flag_d;
  logic             irq_q,      irq_d;

  // Synchronizer chain: plain flop-to-flop shift, nothing between stages.
  always_comb begin
    sync_chain_d[0] = bus.PAD_IN;
    for (int s = 1; s < SYNC_STAGES; s++) begin
      sync_chain_d[s] = sync_chain_q[s-1];
    end
  end

  // Synchronizer registers, loaded with the reset level.
  always_ff @(posedge clk) begin
    for (int s = 0; s < SYNC_STAGES; s++) begin
      if (rst) begin
        sync_chain_q[s] <= RESET_LEVEL;
      end else begin
        sync_chain_q[s] <= sync_chain_d[s];
      end
    end
  end

  assign sync_q = sync_chain_q[SYNC_STAGES-1];

  // Per-bit persistence filter: level only moves after FILTER_CYCLES
  // consecutive disagreeing samples; any agreeing sample restarts the count.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             lvl_d;

    // Next count and next filtered level for this bit.
    always_comb begin
      cnt_d = cnt_q;
      lvl_d = level_q[gi];
      if (sync_q[gi] == level_q[gi]) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_MAX) begin
        lvl_d = sync_q[gi];
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    // Counter register; reset discards any partial count.
    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign level_d[gi] = lvl_d;
  end

  // Edge detect on the next level so pulses line up with the new level,
  // then sticky flags (a new edge beats a simultaneous clear) and irq.
  always_comb begin
    rise_d     = level_d & ~level_q;
    fall_d     = ~level_d & level_q;
    evt_flag_d = (evt_flag_q & ~bus.evt_clr) | rise_q | fall_q;
    irq_d      = |(evt_flag_q & bus.irq_mask);
  end

  // Output registers; reset never generates an edge pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      level_q    <= RESET_LEVEL;
      rise_q     <= '0;
      fall_q     <= '0;
      evt_flag_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      level_q    <= level_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      evt_flag_q <= evt_flag_d;
      irq_q      <= irq_d;
    end
  end

  assign bus.level_out  = level_q;
  assign bus.rise_pulse = rise_q;
  assign bus.fall_pulse = fall_q;
  assign bus.evt_flag   = evt_flag_q;
  assign bus.irq        = irq_q;

endmodule

// File: doc/dm_pad_input_filter.md
Name: dm_pad_input_filter

Overview:
- Input-side counterpart to the team's 4-bit LVCMOS33 output pad buffer on the DM interface board (SmartFusion2 M2S025).
- Takes asynchronous input pads (DM driver status, fault and ready lines) and synchronizes them into the fabric clock domain.
- Glitch-filters each bit with a per-bit persistence counter.
- Produces filtered levels, single-cycle edge pulses, sticky per-bit event flags and a masked interrupt for the fabric register block.

Parameters:
- WIDTH, 4, number of pad bits (matches the output pad group width).
- SYNC_STAGES, 2, synchronizer flop depth (legal range 2..4).
- FILTER_CYCLES, 16, consecutive synchronized samples required before the filtered level changes (legal range 1..65535).
- RESET_LEVEL, 0, WIDTH-bit value loaded into the synchronizer and filtered level on reset.

Ports:
- clk  in  1  fabric clock; all logic is on its rising edge.
- rst  in  1  synchronous, active-high reset.
- PAD_IN  in  WIDTH  raw asynchronous pad inputs.
- evt_clr  in  WIDTH  write-one-to-clear strobe for the sticky event flags.
- irq_mask  in  WIDTH  per-bit interrupt enable (1 = enabled).
- level_out  out  WIDTH  filtered, synchronized level.
- rise_pulse  out  WIDTH  one-cycle pulse on a filtered 0->1 transition.
- fall_pulse  out  WIDTH  one-cycle pulse on a filtered 1->0 transition.
- evt_flag  out  WIDTH  sticky "any filtered edge seen" flag per bit.
- irq  out  1  OR-reduction of (evt_flag & irq_mask), registered.

Behaviour:
- Reset: one clock and reset only; reset is synchronous and active-high. While rst=1 at a clk edge:
  - synchronizer chain <= RESET_LEVEL; level_out <= RESET_LEVEL;
  - all counters <= 0; rise_pulse = fall_pulse = 0; evt_flag = 0; irq = 0.
  - Reset asserted mid-filter discards the partial count; no edge pulse is generated by reset itself.
- Synchronizer:
  - Each bit passes through SYNC_STAGES flops. The last stage is sync_q.
  - No logic sits between stages.
- Filter (independent per bit i):
  - If sync_q[i] == level_out[i]: cnt[i] <= 0.
  - Else if cnt[i] == FILTER_CYCLES-1: level_out[i] <= sync_q[i] and cnt[i] <= 0.
  - Else: cnt[i] <= cnt[i]+1.
  - Counter width is clog2(FILTER_CYCLES) and at least 1. The counter never wraps; it is bounded by the compare.
  - FILTER_CYCLES=1 means level_out follows sync_q with 1 cycle of delay.
- Latency: from a pad change that meets setup before edge 0 and is held, level_out changes on edge SYNC_STAGES+FILTER_CYCLES-1, i.e. after SYNC_STAGES+FILTER_CYCLES edges. Defaults: 18 cycles.
- Glitch rejection: any excursion lasting fewer than FILTER_CYCLES consecutive sync_q samples produces no level change, no pulse and no flag. A single sample back at the current level restarts the count from 0.
- Edge pulses:
  - rise_pulse[i] and fall_pulse[i] are registered. Each is high for exactly the one cycle in which level_out[i] has just taken its new value.
  - They are never both high for the same bit.
- Sticky flags:
  - evt_flag[i] <= (evt_flag[i] & ~evt_clr[i]) | rise_pulse[i] | fall_pulse[i].
  - A new edge in the same cycle as clear wins: the flag stays 1.
  - evt_clr on a bit whose flag is 0 has no effect.
- irq: irq <= |(evt_flag & irq_mask). It is 1 cycle behind evt_flag. Masking is level-based: unmasking a set flag raises irq next cycle.
- All bits are fully independent. Simultaneous edges on multiple bits each produce their own pulses and flags in the same cycle.

Test Plan:
- Reset/defaults: hold rst 3 cycles with PAD_IN=4'hF -> level_out=4'h0, all pulses 0, evt_flag=0, irq=0. After release, PAD_IN held at F -> level_out=4'hF exactly 18 edges later, rise_pulse=4'hF for 1 cycle, evt_flag=4'hF.
- Glitch rejection: level 0; PAD_IN[0] high for 15 cycles then low -> level_out[0] stays 0, no pulse. Then high for 16 cycles -> level_out[0]=1, rise_pulse[0] single cycle.
- Count restart: PAD_IN[2] high 10 cycles, low 1 cycle, high 16 cycles -> transition occurs 16+2 edges after the final rising pad edge, not earlier.
- Flag/clear race: evt_flag[1]=1; assert evt_clr[1] in the same cycle as a new fall_pulse[1] -> evt_flag[1] remains 1. Clear alone next cycle -> 0.
- irq masking: evt_flag=4'b0100 with irq_mask=0 -> irq=0. Set irq_mask=4'b0100 -> irq=1 one cycle later. Clear flag -> irq=0 one cycle after evt_flag drops.
- Reset mid-filter with FILTER_CYCLES=16: pad high 10 cycles then assert rst -> cnt cleared, no pulse. After release with pad still high -> transition a full 18 edges after release.
